sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce_pkg.sv | 23 ++
 rtl/sw_debounce_bit.sv | 65 ++++++
 rtl/sw_debounce.sv | 76 +++++++
 tb/tb_sw_debounce.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared constants and types for the switch debouncer.
//   SW_WIDTH        default number of switch channels
//   SW_TICK_DIV     default sample period in clk cycles
//   SW_STABLE_CNT   default number of agreeing samples to accept a change
//   deb_evt_t       per-channel edge event (rise/fall) decided this cycle
package sw_debounce_pkg;

  localparam int unsigned SW_WIDTH      = 32;
  localparam int unsigned SW_TICK_DIV   = 50000;
  localparam int unsigned SW_STABLE_CNT = 4;

  // Edge event for one channel, valid in the cycle of the accepting tick.
  typedef struct packed {
    logic rise;
    logic fall;
  } deb_evt_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One debounced switch channel.
//   clk, rst   clock and synchronous active-high reset
//   tick       sample strobe from the shared prescaler
//   sw_in      raw asynchronous switch level
//   sw_out     debounced level
//   rise/fall  one-cycle pulses following an accepted 0->1 / 1->0 change
//   evt_c      the rise/fall decision being registered this cycle
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = SW_STABLE_CNT
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     tick,
  input  logic     sw_in,
  output logic     sw_out,
  output logic     rise,
  output logic     fall,
  output deb_evt_t evt_c
);

  logic                  sync1;
  logic                  sync2;
  logic [STABLE_CNT-1:0] hist;
  logic [STABLE_CNT-1:0] hist_next;
  logic                  level_next;

  // Shift on tick; accept only a history that fully disagrees with sw_out.
  always_comb begin
    hist_next  = hist;
    level_next = sw_out;
    evt_c      = '0;
    if (tick) begin
      hist_next = {hist[STABLE_CNT-2:0], sync2};
      if ((&hist_next) && !sw_out) begin
        level_next = 1'b1;
        evt_c.rise = 1'b1;
      end else if (!(|hist_next) && sw_out) begin
        level_next = 1'b0;
        evt_c.fall = 1'b1;
      end
    end
  end

  // Two-flop synchronizer, history and registered level/pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      hist   <= '0;
      sw_out <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync1  <= sw_in;
      sync2  <= sync1;
      hist   <= hist_next;
      sw_out <= level_next;
      rise   <= evt_c.rise;
      fall   <= evt_c.fall;
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer with a shared sample prescaler.
//   clk, rst   clock and synchronous active-high reset
//   sw_in      raw asynchronous switch levels, WIDTH bits
//   sw_out     debounced levels (feeds the SW input of riscv_single_bus_top)
//   rise/fall  per-bit one-cycle pulses on accepted 0->1 / 1->0 changes
//   changed    OR of all rise/fall pulses, aligned with them
//   tick       sample strobe, one cycle per TICK_DIV cycles
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned WIDTH      = SW_WIDTH,
  parameter int unsigned TICK_DIV   = SW_TICK_DIV,
  parameter int unsigned STABLE_CNT = SW_STABLE_CNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic             tick
);

  localparam int unsigned    CNT_W   = cnt_width(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             tick_next;
  logic             changed_next;
  logic [WIDTH-1:0] rise_set;
  logic [WIDTH-1:0] fall_set;

  // tick is registered from the upcoming count so it is high while cnt == CNT_MAX.
  always_comb begin
    cnt_next     = (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    tick_next    = (cnt_next == CNT_MAX);
    changed_next = |(rise_set | fall_set);
  end

  // Prescaler and aggregate change flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      tick    <= 1'b0;
      changed <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      tick    <= tick_next;
      changed <= changed_next;
    end
  end

  // Independent debounce channel per switch bit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    deb_evt_t evt;

    sw_debounce_bit #(
      .STABLE_CNT(STABLE_CNT)
    ) u_bit (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .sw_in  (sw_in[gi]),
      .sw_out (sw_out[gi]),
      .rise   (rise[gi]),
      .fall   (fall[gi]),
      .evt_c  (evt)
    );

    assign rise_set[gi] = evt.rise;
    assign fall_set[gi] = evt.fall;
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with TICK_DIV=4, STABLE_CNT=3, WIDTH=32.
// Cycle n counts from the first cycle after the last reset edge (cnt=0 there),
// so ticks fall on n = 3, 7, 11, ... and an input changed in cycle n0 is
// accepted with sw_out/pulses visible in cycle n0 + 12 when n0 = 0 mod 4.
module tb_sw_debounce;

  typedef logic [97:0] obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sw_in;
  logic [31:0] sw_out;
  logic [31:0] rise;
  logic [31:0] fall;
  logic        changed;
  logic        tick;
  obs_t        obs;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sw_debounce #(
    .WIDTH      (32),
    .TICK_DIV   (4),
    .STABLE_CNT (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_in   (sw_in),
    .sw_out  (sw_out),
    .rise    (rise),
    .fall    (fall),
    .changed (changed),
    .tick    (tick)
  );

  assign obs = {sw_out, rise, fall, changed, tick};

  function automatic obs_t mk(input logic [31:0] so, input logic [31:0] r,
                              input logic [31:0] f, input logic c, input logic t);
    return {so, r, f, c, t};
  endfunction

  // Two reset edges, then release in cycle 0 with sw_in = v.
  task automatic apply_reset(input logic [31:0] v);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    sw_in = v;
  endtask

  task automatic test_reset();
    obs_t e;
    @(negedge clk);
    rst   = 1'b1;
    sw_in = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      e = '0;
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset_hold cyc=%0d got %h want %h", i, obs, e);
      end
    end
    rst   = 1'b0;
    sw_in = 32'h0;
    for (int n = 0; n < 16; n++) begin
      e = mk(32'h0, 32'h0, 32'h0, 1'b0, (n % 4) == 3);
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset_release n=%0d got %h want %h", n, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_press();
    obs_t e;
    apply_reset(32'h0);
    sw_in[0] = 1'b1;
    for (int n = 0; n < 18; n++) begin
      e = mk((n >= 12) ? 32'h1 : 32'h0, (n == 12) ? 32'h1 : 32'h0, 32'h0,
             n == 12, (n % 4) == 3);
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL press n=%0d got %h want %h", n, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_bounce();
    obs_t e;
    apply_reset(32'h0);
    for (int n = 0; n < 64; n++) begin
      sw_in[5] = (n < 40) ? (((n / 3) % 2) == 0) : 1'b0;
      e = mk(32'h0, 32'h0, 32'h0, 1'b0, (n % 4) == 3);
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL bounce n=%0d got %h want %h", n, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_simultaneous();
    obs_t e;
    apply_reset(32'h8000_0000);
    for (int n = 0; n < 28; n++) begin
      e = mk((n < 12) ? 32'h0 : ((n < 24) ? 32'h8000_0000 : 32'h1),
             (n == 12) ? 32'h8000_0000 : ((n == 24) ? 32'h1 : 32'h0),
             (n == 24) ? 32'h8000_0000 : 32'h0,
             (n == 12) || (n == 24), (n % 4) == 3);
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL simultaneous n=%0d got %h want %h", n, obs, e);
      end
      if (n == 12) sw_in = 32'h1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    obs_t e;
    logic t;
    apply_reset(32'h8);
    for (int n = 0; n < 25; n++) begin
      t = (n <= 8) ? ((n % 4) == 3) : (((n - 9) % 4) == 3);
      e = mk((n >= 21) ? 32'h8 : 32'h0, (n == 21) ? 32'h8 : 32'h0, 32'h0,
             n == 21, t);
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset_mid n=%0d got %h want %h", n, obs, e);
      end
      if (n == 8) rst = 1'b1;
      if (n == 9) rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_pattern();
    obs_t e;
    apply_reset(32'hA5A5_A5A5);
    for (int n = 0; n < 28; n++) begin
      e = mk(((n >= 12) && (n < 24)) ? 32'hA5A5_A5A5 : 32'h0,
             (n == 12) ? 32'hA5A5_A5A5 : 32'h0,
             (n == 24) ? 32'hA5A5_A5A5 : 32'h0,
             (n == 12) || (n == 24), (n % 4) == 3);
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL pattern n=%0d got %h want %h", n, obs, e);
      end
      if (n == 12) sw_in = 32'h0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst   = 1'b1;
    sw_in = 32'h0;
    test_reset();
    test_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_pattern();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
